// File: rtl/irq_wb_ctrl_pkg.sv
// Shared widths, CSR addresses, cause codes and FSM encoding for the
// machine-mode interrupt sequencer in front of the mem/wb register.
package irq_wb_ctrl_pkg;

  localparam int RDATA_WIDTH    = 32;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ZERO_ADDR = 12'h000;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIE       = 12'h304;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE    = 12'h342;

  localparam logic [3:0] IRQ_CAUSE_MEI = 4'd11;
  localparam logic [3:0] IRQ_CAUSE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CAUSE_MTI = 4'd7;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;  // low bit of the 2-bit MPP field

  typedef enum logic [3:0] {
    ST_IDLE, ST_FLUSH, ST_WR_MEPC, ST_WR_MCAUSE, ST_WR_MSTATUS, ST_REDIRECT,
    ST_FLUSH_R, ST_WR_MSTATUS_R, ST_REDIRECT_R
  } irq_state_e;

  typedef struct packed {
    logic                      we;
    logic [CSR_ADDR_WIDTH-1:0] addr;
    logic [RDATA_WIDTH-1:0]    data;
  } csr_req_t;

  function automatic logic [RDATA_WIDTH-1:0] mstatus_on_trap(input logic [RDATA_WIDTH-1:0] s);
    mstatus_on_trap                      = s;
    mstatus_on_trap[MSTATUS_MPIE]        = s[MSTATUS_MIE];
    mstatus_on_trap[MSTATUS_MIE]         = 1'b0;
    mstatus_on_trap[MSTATUS_MPP +: 2]    = 2'b11;
  endfunction

  function automatic logic [RDATA_WIDTH-1:0] mstatus_on_mret(input logic [RDATA_WIDTH-1:0] s);
    mstatus_on_mret                      = s;
    mstatus_on_mret[MSTATUS_MIE]         = s[MSTATUS_MPIE];
    mstatus_on_mret[MSTATUS_MPIE]        = 1'b1;
    mstatus_on_mret[MSTATUS_MPP +: 2]    = 2'b11;
  endfunction

endpackage

// File: rtl/irq_wb_ctrl_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI.
module irq_prio_enc
  import irq_wb_ctrl_pkg::*;
(
  input  logic [2:0] pending,  // {mei, msi, mti}
  input  logic [2:0] enable,   // {mie[11], mie[3], mie[7]}
  output logic       valid,
  output logic [3:0] cause
);

  logic [2:0] act;
  assign act   = pending & enable;
  assign valid = |act;

  always_comb begin
    cause = IRQ_CAUSE_MTI;
    if (act[2])      cause = IRQ_CAUSE_MEI;
    else if (act[1]) cause = IRQ_CAUSE_MSI;
  end

endmodule

// File: rtl/irq_wb_ctrl.sv
// Interrupt / mret sequencer: flushes mem/wb, writes trap CSRs one per cycle
// through the shared CSR port, then redirects fetch.
module irq_wb_ctrl
  import irq_wb_ctrl_pkg::*;
#(
  parameter bit MTVEC_VECTORED = 1'b1
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      ext_irq_in,
  input  logic                      sw_irq_in,
  input  logic                      timer_irq_in,
  input  logic [RDATA_WIDTH-1:0]    mstatus_in,
  input  logic [RDATA_WIDTH-1:0]    mie_in,
  input  logic [RDATA_WIDTH-1:0]    mtvec_in,
  input  logic [RDATA_WIDTH-1:0]    mepc_in,
  input  logic                      inst_valid_in,
  input  logic [RDATA_WIDTH-1:0]    inst_pc_in,
  input  logic                      mret_in,
  input  logic                      pipe_csr_we_in,
  input  logic [CSR_ADDR_WIDTH-1:0] pipe_csr_waddr_in,
  input  logic [RDATA_WIDTH-1:0]    pipe_csr_wdata_in,
  output logic                      interrupt_flush_out,
  output logic                      stall_out,
  output logic                      csr_we_out,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_out,
  output logic [RDATA_WIDTH-1:0]    csr_wdata_out,
  output logic                      pc_redirect_out,
  output logic [RDATA_WIDTH-1:0]    pc_target_out
);

  irq_state_e             state_q, state_d;
  logic [RDATA_WIDTH-1:0] epc_q;
  logic [3:0]             cause_q;
  logic                   irq_vld;
  logic [3:0]             irq_cause;
  logic                   take;
  csr_req_t               csr;
  logic                   unused_mie;

  assign unused_mie = ^mie_in;

  irq_prio_enc u_prio (
    .pending ({ext_irq_in, sw_irq_in, timer_irq_in}),
    .enable  ({mie_in[11], mie_in[3], mie_in[7]}),
    .valid   (irq_vld),
    .cause   (irq_cause)
  );

  assign take = mstatus_in[MSTATUS_MIE] & irq_vld & inst_valid_in;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && take) begin
        epc_q   <= inst_pc_in;
        cause_q <= irq_cause;
      end
    end
  end

  // Interrupt beats a coincident mret; the mret is voided by the flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take)                        state_d = ST_FLUSH;
        else if (mret_in && inst_valid_in) state_d = ST_FLUSH_R;
      end
      ST_FLUSH:        state_d = ST_WR_MEPC;
      ST_WR_MEPC:      state_d = ST_WR_MCAUSE;
      ST_WR_MCAUSE:    state_d = ST_WR_MSTATUS;
      ST_WR_MSTATUS:   state_d = ST_REDIRECT;
      ST_REDIRECT:     state_d = ST_IDLE;
      ST_FLUSH_R:      state_d = ST_WR_MSTATUS_R;
      ST_WR_MSTATUS_R: state_d = ST_REDIRECT_R;
      ST_REDIRECT_R:   state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    interrupt_flush_out = 1'b0;
    stall_out           = (state_q != ST_IDLE);
    pc_redirect_out     = 1'b0;
    pc_target_out       = '0;
    csr                 = '{we: 1'b0, addr: CSR_ZERO_ADDR, data: '0};
    case (state_q)
      ST_IDLE:
        csr = '{we: pipe_csr_we_in, addr: pipe_csr_waddr_in, data: pipe_csr_wdata_in};
      ST_FLUSH, ST_FLUSH_R:
        interrupt_flush_out = 1'b1;
      ST_WR_MEPC:
        csr = '{we: 1'b1, addr: CSR_MEPC, data: {epc_q[RDATA_WIDTH-1:2], 2'b00}};
      ST_WR_MCAUSE: begin
        csr                     = '{we: 1'b1, addr: CSR_MCAUSE, data: '0};
        csr.data[RDATA_WIDTH-1] = 1'b1;
        csr.data[3:0]           = cause_q;
      end
      ST_WR_MSTATUS:
        csr = '{we: 1'b1, addr: CSR_MSTATUS, data: mstatus_on_trap(mstatus_in)};
      ST_WR_MSTATUS_R:
        csr = '{we: 1'b1, addr: CSR_MSTATUS, data: mstatus_on_mret(mstatus_in)};
      ST_REDIRECT: begin
        pc_redirect_out = 1'b1;
        pc_target_out   = {mtvec_in[RDATA_WIDTH-1:2], 2'b00};
        if (MTVEC_VECTORED && mtvec_in[1:0] == 2'b01)
          pc_target_out = pc_target_out + {{(RDATA_WIDTH-6){1'b0}}, cause_q, 2'b00};
      end
      ST_REDIRECT_R: begin
        pc_redirect_out = 1'b1;
        pc_target_out   = mepc_in;
      end
      default: ;
    endcase
    // Everything, including the pass-through, is held quiet during reset.
    if (!reset_in) begin
      interrupt_flush_out = 1'b0;
      stall_out           = 1'b0;
      pc_redirect_out     = 1'b0;
      pc_target_out       = '0;
      csr                 = '{we: 1'b0, addr: CSR_ZERO_ADDR, data: '0};
    end
  end

  assign csr_we_out    = csr.we;
  assign csr_waddr_out = csr.addr;
  assign csr_wdata_out = csr.data;

endmodule

// File: tb/tb_irq_wb_ctrl.sv
// Directed bench for irq_wb_ctrl: cycle-level schedule model plus literal checks.
module tb_irq_wb_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        ext_irq_in, sw_irq_in, timer_irq_in;
  logic [31:0] mstatus_in, mie_in, mtvec_in, mepc_in, inst_pc_in;
  logic        inst_valid_in, mret_in;
  logic        pipe_csr_we_in;
  logic [11:0] pipe_csr_waddr_in;
  logic [31:0] pipe_csr_wdata_in;
  logic        interrupt_flush_out, stall_out, csr_we_out, pc_redirect_out;
  logic [11:0] csr_waddr_out;
  logic [31:0] csr_wdata_out, pc_target_out;

  int total = 0;
  int bad   = 0;

  irq_wb_ctrl #(.MTVEC_VECTORED(1'b1)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .ext_irq_in(ext_irq_in), .sw_irq_in(sw_irq_in), .timer_irq_in(timer_irq_in),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .inst_valid_in(inst_valid_in), .inst_pc_in(inst_pc_in), .mret_in(mret_in),
    .pipe_csr_we_in(pipe_csr_we_in), .pipe_csr_waddr_in(pipe_csr_waddr_in),
    .pipe_csr_wdata_in(pipe_csr_wdata_in),
    .interrupt_flush_out(interrupt_flush_out), .stall_out(stall_out),
    .csr_we_out(csr_we_out), .csr_waddr_out(csr_waddr_out), .csr_wdata_out(csr_wdata_out),
    .pc_redirect_out(pc_redirect_out), .pc_target_out(pc_target_out)
  );

  always #5 clk_in = ~clk_in;

  // Model: a queue of the remaining cycles of the current sequence.
  typedef enum {K_FLUSH, K_MEPC, K_MCAUSE, K_MST, K_REDIR, K_FLUSH_R, K_MST_R, K_REDIR_R} kind_e;
  kind_e       sched[$];
  logic [31:0] m_epc;
  logic [31:0] m_cause;

  always @(posedge clk_in) begin
    if (!reset_in) sched.delete();
    else if (sched.size() != 0) void'(sched.pop_front());
    else if (mstatus_in[3] && inst_valid_in &&
             ((ext_irq_in && mie_in[11]) || (sw_irq_in && mie_in[3]) || (timer_irq_in && mie_in[7]))) begin
      m_epc   = inst_pc_in;
      m_cause = (ext_irq_in && mie_in[11]) ? 11 : (sw_irq_in && mie_in[3]) ? 3 : 7;
      sched   = '{K_FLUSH, K_MEPC, K_MCAUSE, K_MST, K_REDIR};
    end else if (mret_in && inst_valid_in)
      sched = '{K_FLUSH_R, K_MST_R, K_REDIR_R};
  end

  function automatic logic [79:0] model_out();
    logic f, s, we, rd;
    logic [11:0] a;
    logic [31:0] d, t;
    f = 0; s = 0; we = 0; rd = 0; a = 0; d = 0; t = 0;
    if (!reset_in) ;
    else if (sched.size() == 0) begin
      we = pipe_csr_we_in; a = pipe_csr_waddr_in; d = pipe_csr_wdata_in;
    end else begin
      s = 1;
      case (sched[0])
        K_FLUSH, K_FLUSH_R: f = 1;
        K_MEPC:   begin we = 1; a = 12'h341; d = m_epc & ~32'd3; end
        K_MCAUSE: begin we = 1; a = 12'h342; d = 32'h8000_0000 | m_cause; end
        K_MST:    begin we = 1; a = 12'h300;
                        d = (mstatus_in & ~32'h1888) | 32'h1800 | (mstatus_in[3] ? 32'h80 : 32'h0); end
        K_MST_R:  begin we = 1; a = 12'h300;
                        d = (mstatus_in & ~32'h1888) | 32'h1880 | (mstatus_in[7] ? 32'h8 : 32'h0); end
        K_REDIR:  begin rd = 1;
                        t = (mtvec_in & ~32'd3) + ((mtvec_in[1:0] == 2'b01) ? m_cause * 4 : 32'd0); end
        K_REDIR_R: begin rd = 1; t = mepc_in; end
        default: ;
      endcase
    end
    return {f, s, we, a, d, rd, t};
  endfunction

  logic rst_window = 0;
  logic saw_mst    = 0;

  always @(negedge clk_in) begin
    logic [79:0] exp_v, act_v;
    exp_v = model_out();
    act_v = {interrupt_flush_out, stall_out, csr_we_out, csr_waddr_out, csr_wdata_out,
             pc_redirect_out, pc_target_out};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL cycle_model t=%0t act=%h exp=%h", $time, act_v, exp_v);
    end
    if (rst_window && csr_we_out && csr_waddr_out == 12'h300) saw_mst = 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #2;
  endtask

  task automatic quiet();
    {ext_irq_in, sw_irq_in, timer_irq_in, inst_valid_in, mret_in} = '0;
  endtask

  initial begin
    reset_in = 0; quiet();
    mstatus_in = 0; mie_in = 0; mtvec_in = 0; mepc_in = 0; inst_pc_in = 0;
    pipe_csr_we_in = 0; pipe_csr_waddr_in = 0; pipe_csr_wdata_in = 0;
    tick(); tick();
    chk("rst_we", {31'd0, csr_we_out}, 0);
    chk("rst_addr", {20'd0, csr_waddr_out}, 0);
    chk("rst_stall", {31'd0, stall_out}, 0);
    reset_in = 1; tick();

    // MTI, direct mode
    mstatus_in = 32'h8; mie_in = 32'h80; mtvec_in = 32'h200;
    timer_irq_in = 1; inst_valid_in = 1; inst_pc_in = 32'h100;
    tick(); quiet();
    chk("mti_flush", {31'd0, interrupt_flush_out}, 1);
    chk("mti_stall", {31'd0, stall_out}, 1);
    tick(); chk("mti_mepc_a", {20'd0, csr_waddr_out}, 32'h341); chk("mti_mepc_d", csr_wdata_out, 32'h100);
    tick(); chk("mti_mcause", csr_wdata_out, 32'h8000_0007);
    tick(); chk("mti_mst_a", {20'd0, csr_waddr_out}, 32'h300); chk("mti_mst_d", csr_wdata_out, 32'h1880);
    tick(); chk("mti_redir", {31'd0, pc_redirect_out}, 1); chk("mti_target", pc_target_out, 32'h200);
    tick(); chk("mti_idle", {31'd0, stall_out}, 0);

    // all pending, vectored, coincident mret, unaligned pc
    mie_in = 32'h888; mtvec_in = 32'h201; inst_pc_in = 32'h106;
    {ext_irq_in, sw_irq_in, timer_irq_in, inst_valid_in, mret_in} = '1;
    tick(); quiet();
    tick(); chk("prio_mepc", csr_wdata_out, 32'h104);
    tick(); chk("prio_mcause", csr_wdata_out, 32'h8000_000B);
    tick(); tick(); chk("prio_target", pc_target_out, 32'h22C);
    tick();

    // mret
    mstatus_in = 32'h80; mepc_in = 32'h104; mret_in = 1; inst_valid_in = 1;
    tick(); quiet(); chk("mret_flush", {31'd0, interrupt_flush_out}, 1);
    tick(); chk("mret_mst", csr_wdata_out, 32'h1888);
    tick(); chk("mret_target", pc_target_out, 32'h104);
    tick();

    // arbitration
    pipe_csr_we_in = 1; pipe_csr_waddr_in = 12'h340; pipe_csr_wdata_in = 32'hDEAD; #1;
    chk("pass_addr", {20'd0, csr_waddr_out}, 32'h340);
    chk("pass_data", csr_wdata_out, 32'hDEAD);
    mstatus_in = 32'h8; mie_in = 32'h80; mtvec_in = 32'h200; timer_irq_in = 1; inst_valid_in = 1;
    tick(); quiet(); tick(); tick();
    chk("arb_mcause_a", {20'd0, csr_waddr_out}, 32'h342);
    tick(); tick(); tick();

    // masked
    mstatus_in = 32'h0; mie_in = 32'h888; {ext_irq_in, sw_irq_in, timer_irq_in, inst_valid_in} = '1;
    tick(); tick();
    chk("mask_flush", {31'd0, interrupt_flush_out}, 0);
    chk("mask_pass", csr_wdata_out, 32'hDEAD);
    quiet(); pipe_csr_we_in = 0;

    // reset during WR_MCAUSE
    mstatus_in = 32'h8; mie_in = 32'h80; timer_irq_in = 1; inst_valid_in = 1;
    tick(); quiet(); tick(); tick();
    chk("pre_rst_mcause", {20'd0, csr_waddr_out}, 32'h342);
    reset_in = 0; rst_window = 1; #1;
    chk("rst_mid_we", {31'd0, csr_we_out}, 0);
    tick();
    chk("rst_mid_stall", {31'd0, stall_out}, 0);
    chk("rst_mid_addr", {20'd0, csr_waddr_out}, 0);
    reset_in = 1; tick();
    chk("post_rst_idle", {31'd0, stall_out}, 0);
    repeat (4) tick();
    chk("no_mst_after_rst", {31'd0, saw_mst}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_wb_ctrl.md
# irq_wb_ctrl

Machine-mode interrupt sequencer that drives the mem/wb pipeline register's `interrupt_flush_in` and owns its CSR write port. When an enabled interrupt is taken, or `mret` retires, it:
- flushes mem/wb;
- writes `mepc`/`mcause`/`mstatus` one per cycle through the existing CSR writeback path;
- redirects fetch.

In IDLE it passes the mem stage's CSR write request through unchanged.

## Interface
- `MTVEC_VECTORED`, 1: honour `mtvec[1:0]==01` vectored mode; 0 = always direct.
- `clk_in`  in  1  clock, all state on rising edge
- `reset_in`  in  1  synchronous, active-low reset
- `ext_irq_in` / `sw_irq_in` / `timer_irq_in`  in  1 each  level interrupt lines (MEI/MSI/MTI)
- `mstatus_in`  in  `RDATA_WIDTH`  current mstatus
- `mie_in`  in  `RDATA_WIDTH`  current mie
- `mtvec_in` / `mepc_in`  in  `RDATA_WIDTH`  current mtvec / mepc
- `inst_valid_in`  in  1  mem stage holds a valid instruction
- `inst_pc_in`  in  `RDATA_WIDTH`  PC of that instruction
- `mret_in`  in  1  mem-stage instruction is `mret`
- `pipe_csr_we_in` / `pipe_csr_waddr_in` / `pipe_csr_wdata_in`  in  1 / `CSR_ADDR_WIDTH` / `RDATA_WIDTH`  CSR write from mem stage
- `interrupt_flush_out`  out  1  to mem/wb and earlier stages
- `stall_out`  out  1  freeze fetch/decode while sequencing
- `csr_we_out` / `csr_waddr_out` / `csr_wdata_out`  out  1 / `CSR_ADDR_WIDTH` / `RDATA_WIDTH`  to mem/wb CSR inputs
- `pc_redirect_out`  out  1  one-cycle fetch redirect strobe
- `pc_target_out`  out  `RDATA_WIDTH`  redirect target

## Operation
- **Take condition, IDLE only:** `take = mstatus_in[3] & |({ext,sw,timer} & {mie_in[11],mie_in[3],mie_in[7]}) & inst_valid_in`.
- **Priority:** MEI (cause 11) > MSI (3) > MTI (7).
- **On take:** latch `inst_pc_in` → `epc_q` and the cause; go FLUSH.
- **Else on `mret_in & inst_valid_in`:** go FLUSH_R.
- **Interrupt path:** FLUSH → WR_MEPC → WR_MCAUSE → WR_MSTATUS → REDIRECT → IDLE.
- **mret path:** FLUSH_R → WR_MSTATUS_R → REDIRECT_R → IDLE.
- **Interrupt and mret in the same cycle:** interrupt wins. `epc_q` = PC of the `mret`; the `mret` is discarded.
- **CSR write data:**
  - WR_MEPC: addr 0x341, data `epc_q & ~3`.
  - WR_MCAUSE: addr 0x342, data `{1'b1, 27'b0, cause}`.
  - WR_MSTATUS: addr 0x300, data = `mstatus_in` with MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← 2'b11.
  - WR_MSTATUS_R: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
- **Redirect target:**
  - REDIRECT: `{mtvec_in[31:2],2'b00}`. If `MTVEC_VECTORED` and `mtvec_in[1:0]==01`, add `cause<<2` (32-bit wrap).
  - REDIRECT_R: `mepc_in` sampled that cycle; the WR_MSTATUS_R write has landed by then.
- **CSR port arbitration:**
  - IDLE: `csr_*_out` = `pipe_csr_*_in` (combinational mux).
  - Any other state: controller owns the port; pipe requests are dropped. The flush voids those instructions.
- **Interrupt lines outside IDLE:** ignored. Re-evaluated on return to IDLE; MIE is then 0 unless software re-enables it.

## Timing
- **Detect at cycle T:**
  - T+1: `interrupt_flush_out`=1, `stall_out`=1.
  - T+2..T+4: one CSR write per cycle, `csr_we_out`=1.
  - T+5: `pc_redirect_out`=1.
  - T+6: IDLE.
- **mret detect at T:**
  - T+1: flush.
  - T+2: mstatus write.
  - T+3: redirect.
- **`stall_out`:** 1 in every non-IDLE state.
- **`interrupt_flush_out`:** 1 only in FLUSH/FLUSH_R.
- **`pc_redirect_out`:** 1 only in REDIRECT/REDIRECT_R.
- **Reset (`reset_in`=0 at any edge, including mid-sequence):**
  - State returns to IDLE; `epc_q`, cause ← 0.
  - No partial writes complete after the reset edge.
  - Controller outputs are 0; `csr_waddr_out` = `CSR_ZERO_ADDR`.
  - The IDLE pass-through is also forced to 0 while reset is asserted.
- No combinational path from interrupt lines to any output.

## Structure
- **`defines.v` additions:**
  - CSR addresses `CSR_MSTATUS` 12'h300, `CSR_MIE` 12'h304, `CSR_MTVEC` 12'h305, `CSR_MEPC` 12'h341, `CSR_MCAUSE` 12'h342.
  - Cause codes `IRQ_CAUSE_MEI/MSI/MTI`.
  - mstatus bit indices `MSTATUS_MIE/MPIE/MPP`.
  - State encodings.
- **Sub-module `irq_prio_enc`:** combinational; inputs pending and enable bits; outputs `valid` and a 4-bit cause.

## Test plan
- **MTI:** `mstatus_in`=0x8, `mie_in`=0x80, `timer_irq_in`=1, `inst_pc_in`=0x100 → flush at T+1.
  - Writes: 0x341←0x100, 0x342←0x80000007, 0x300←0x1880.
  - Redirect to `mtvec_in`=0x200 at T+5.
- **Priority, vectored:** all three lines pending and enabled, `mtvec_in`=0x201 → mcause 0x8000000B, target 0x22C.
- **mret:** `mstatus_in`=0x80, `mepc_in`=0x104, `mret_in`=1 → 0x300←0x1888 at T+2; redirect to 0x104 at T+3.
- **Arbitration:** IDLE pipe write 0x340←0xDEAD passes through same cycle. A pipe write during WR_MCAUSE is dropped; the port shows 0x342.
- **Masked:** `mstatus_in[3]`=0, all lines high → no flush; outputs pass through.
- **Reset mid-sequence:** `reset_in` low at WR_MCAUSE → next cycle all outputs 0, IDLE; no 0x300 write ever issued.
